// File: rtl/sng_sched.sv
// sng_sched: round-robin arbiter sharing one stochastic number generator.
// Runs START/STREAM/STOP/DONE per grant and popcounts the returned stream.
module sng_sched #(
    parameter int  NREQ = 4,
    parameter int  BW   = 4,
    localparam int LEN  = 2**BW,
    localparam int CW   = $clog2(LEN+1)
) (
    input  logic             i_clk_ssc,
    input  logic             i_rst_ssc,
    input  logic [NREQ-1:0]  i_req_ssc,
    input  logic [NREQ*BW-1:0] i_x_ssc,
    output logic [NREQ-1:0]  o_gnt_ssc,
    output logic [BW-1:0]    o_x_bn,
    output logic             o_start_sng,
    output logic             o_stop_sng,
    input  logic             i_sn_bit,
    output logic             o_sn_bit_ssc,
    output logic             o_sn_vld_ssc,
    output logic [CW-1:0]    o_cnt_ssc,
    output logic [NREQ-1:0]  o_done_ssc,
    output logic             o_busy_ssc
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_STOP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, idx_q, pick_idx;
    logic            pick_vld;
    logic [BW-1:0]   x_q, bit_cnt_q;
    logic [CW-1:0]   acc_q, cnt_q;
    logic            bit_q, vld_q;
    logic [NREQ-1:0] sel;
    int              j;

    // Reverse scan so the lowest offset from the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int i = NREQ-1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (i_req_ssc[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign sel = NREQ'(1) << idx_q;

    always_ff @(posedge i_clk_ssc) begin
        if (!i_rst_ssc) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_start_sng = 1'b0;
        o_stop_sng  = 1'b0;
        o_gnt_ssc   = '0;
        o_done_ssc  = '0;
        o_busy_ssc  = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) state_d = S_START;
            end
            S_START: begin
                o_start_sng = 1'b1;
                o_gnt_ssc   = sel;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                o_gnt_ssc = sel;
                if (bit_cnt_q == BW'(LEN-1)) state_d = S_STOP;
            end
            S_STOP: begin
                o_stop_sng = 1'b1;
                o_gnt_ssc  = sel;
                state_d    = S_DONE;
            end
            S_DONE: begin
                o_gnt_ssc  = sel;
                o_done_ssc = sel;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_ssc) begin
        if (!i_rst_ssc) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            bit_cnt_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            bit_q     <= (state_q == S_STREAM) & i_sn_bit;
            vld_q     <= (state_q == S_STREAM);
            bit_cnt_q <= (state_q == S_STREAM) ? bit_cnt_q + 1'b1 : '0;
            if (state_q == S_IDLE && pick_vld) begin
                idx_q <= pick_idx;
                x_q   <= i_x_ssc[pick_idx*BW +: BW];
            end
            if (state_q == S_START) begin
                ptr_q <= (int'(idx_q) == NREQ-1) ? '0 : idx_q + 1'b1;
            end
            if (vld_q) acc_q <= acc_q + CW'(bit_q);
            // Last bit is still in flight during STOP; fold it in here.
            if (state_q == S_STOP) begin
                cnt_q <= acc_q + CW'(bit_q);
                acc_q <= '0;
            end
        end
    end

    assign o_x_bn       = x_q;
    assign o_sn_bit_ssc = bit_q;
    assign o_sn_vld_ssc = vld_q;
    assign o_cnt_ssc    = cnt_q;

endmodule

// File: tb/tb_sng_sched.sv
// tb_sng_sched: directed/random bench for sng_sched with a transaction model.
// Model tracks the round-robin pointer and expected popcount per grant.
module tb_sng_sched;

    localparam int NREQ = 4;
    localparam int BW   = 4;
    localparam int LEN  = 16;
    localparam int CW   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*BW-1:0] xin = '0;
    logic              sn = 1'b0;
    logic [NREQ-1:0]   o_gnt, o_done;
    logic [BW-1:0]     o_x_bn;
    logic              o_start, o_stop, o_bit, o_vld, o_busy;
    logic [CW-1:0]     o_cnt;

    int                n_pass = 0;
    int                n_tot = 0;
    int                mptr = 0;
    int                last_cnt = 0;

    sng_sched #(.NREQ(NREQ), .BW(BW)) dut (
        .i_clk_ssc   (clk),
        .i_rst_ssc   (rst_n),
        .i_req_ssc   (req),
        .i_x_ssc     (xin),
        .o_gnt_ssc   (o_gnt),
        .o_x_bn      (o_x_bn),
        .o_start_sng (o_start),
        .o_stop_sng  (o_stop),
        .i_sn_bit    (sn),
        .o_sn_bit_ssc(o_bit),
        .o_sn_vld_ssc(o_vld),
        .o_cnt_ssc   (o_cnt),
        .o_done_ssc  (o_done),
        .o_busy_ssc  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p+i)%NREQ]) return (p+i)%NREQ;
        end
        return -1;
    endfunction

    function automatic logic [LEN-1:0] ones_bits(input int n);
        logic [LEN-1:0] b;
        b = '0;
        while ($countones(b) < n) b[$urandom_range(LEN-1, 0)] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({o_gnt, o_x_bn, o_start, o_stop, o_bit,
                    o_vld, o_cnt, o_done, o_busy});
    endfunction

    task automatic txn(input int k, input logic [LEN-1:0] bits,
                       input int cnt_exp, input int drop_at,
                       input int rst_at, output int lat);
        logic [NREQ-1:0] oh;
        logic [BW-1:0]   xexp;
        int              vcnt;
        oh   = NREQ'(1) << k;
        xexp = xin[k*BW +: BW];
        vcnt = 0;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_start && lat < 40);
        chk("start_seen", 32'(o_start), 32'(1));
        chk("gnt_start", 32'(o_gnt), 32'(oh));
        chk("x_bn_start", 32'(o_x_bn), 32'(xexp));
        chk("busy_start", 32'(o_busy), 32'(1));
        chk("stop_at_start", 32'(o_stop), 32'(0));
        chk("cnt_held", 32'(o_cnt), 32'(last_cnt));
        mptr = (k + 1) % NREQ;
        xin  = 16'($urandom);
        for (int s = 0; s < LEN; s++) begin
            @(negedge clk);
            if (o_vld) vcnt++;
            chk("vld_stream", 32'(o_vld), 32'(s > 0));
            if (s > 0) chk("bit_fwd", 32'(o_bit), 32'(bits[s-1]));
            chk("gnt_stream", 32'(o_gnt), 32'(oh));
            chk("strobes_stream", 32'({o_start, o_stop, o_done}), 32'(0));
            if (s == rst_at) begin
                rst_n = 1'b0;
                sn    = 1'b0;
                @(negedge clk);
                chk("rst_abort_outs", all_outs(), 32'(0));
                mptr     = 0;
                last_cnt = 0;
                return;
            end
            sn = bits[s];
            if (s == drop_at) req[k] = 1'b0;
        end
        @(negedge clk);
        if (o_vld) vcnt++;
        chk("stop_pulse", 32'({o_start, o_stop}), 32'(1));
        chk("vld_stop", 32'(o_vld), 32'(1));
        chk("bit_last", 32'(o_bit), 32'(bits[LEN-1]));
        chk("x_bn_held", 32'(o_x_bn), 32'(xexp));
        chk("gnt_stop", 32'(o_gnt), 32'(oh));
        sn = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'(oh));
        chk("cnt_done", 32'(o_cnt), 32'(cnt_exp));
        chk("vld_done", 32'(o_vld), 32'(0));
        chk("stop_done", 32'(o_stop), 32'(0));
        chk("vld_count", 32'(vcnt), 32'(LEN));
        last_cnt = cnt_exp;
    endtask

    initial begin
        int             k, lat;
        logic [LEN-1:0] bits;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 32'(0));
        rst_n = 1'b1;

        // req0 alone, operand x with exactly x ones in the stream
        for (int x = 0; x < LEN; x++) begin
            xin      = 16'($urandom);
            xin[3:0] = x[3:0];
            req      = 4'b0001;
            bits     = ones_bits(x);
            k        = pick(req, mptr);
            txn(k, bits, x, -1, -1, lat);
            chk("lat_start", 32'(lat), 32'(1));
            req = '0;
            @(negedge clk);
            chk("idle_after", 32'(o_busy), 32'(0));
        end

        // All four from reset release
        rst_n = 1'b0;
        req   = 4'hF;
        repeat (2) @(negedge clk);
        chk("reset2_outs", all_outs(), 32'(0));
        mptr     = 0;
        last_cnt = 0;
        rst_n    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bits = LEN'($urandom);
            k    = pick(req, mptr);
            txn(k, bits, $countones(bits), -1, -1, lat);
            req[k] = 1'b0;
        end

        // req0 and req2 held continuously
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            bits = LEN'($urandom);
            k    = pick(req, mptr);
            txn(k, bits, $countones(bits), -1, -1, lat);
        end
        req = '0;
        @(negedge clk);
        chk("idle_s3", 32'(o_busy), 32'(0));

        // req1 dropped mid-stream still completes
        req  = 4'b0010;
        bits = LEN'($urandom);
        k    = pick(req, mptr);
        txn(k, bits, $countones(bits), 5, -1, lat);
        @(negedge clk);
        chk("idle_s4", 32'({o_busy, o_gnt}), 32'(0));

        // Reset during stream cycle 7, then req3 restarts fresh
        req  = 4'b1000;
        bits = LEN'($urandom);
        k    = pick(req, mptr);
        txn(k, bits, $countones(bits), -1, 7, lat);
        rst_n = 1'b1;
        bits  = LEN'($urandom);
        k     = pick(req, mptr);
        txn(k, bits, $countones(bits), -1, -1, lat);
        chk("lat_restart", 32'(lat), 32'(1));
        req = '0;
        @(negedge clk);

        // All-ones stream saturates at LEN
        xin[3:0] = 4'hF;
        req      = 4'b0001;
        k        = pick(req, mptr);
        txn(k, {LEN{1'b1}}, LEN, -1, -1, lat);
        req = '0;
        @(negedge clk);

        // Random request mixes
        req = 4'($urandom_range(15, 1));
        for (int i = 0; i < 10; i++) begin
            bits = LEN'($urandom);
            k    = pick(req, mptr);
            txn(k, bits, $countones(bits), -1, -1, lat);
            req[k] = 1'b0;
            req    = req | 4'($urandom_range(15, 0));
            if (req == '0) req = 4'b0100;
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("idle_end", 32'(o_busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
